// File: rtl/serial_sub16.sv
// Bit-serial subtractor: out = a - b (mod 2^WIDTH), one bit per cycle, LSB first.
// Define SERIAL_SUB16_FLAGS_EN to add the registered zr/ng/brw result flags.
module serial_sub16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB16_FLAGS_EN
    ,
    output logic             zr,
    output logic             ng,
    output logic             brw
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             dbit, borrow_nxt;

`ifdef SERIAL_SUB16_FLAGS_EN
    logic zr_q, zr_d, ng_q, ng_d, brw_q, brw_d;
`endif

    // Operands shift right so bit 0 is always the current bit.
    assign dbit       = a_q[0] ^ b_q[0] ^ borrow_q;
    assign borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB16_FLAGS_EN
        zr_d     = zr_q;
        ng_d     = ng_q;
        brw_d    = brw_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                sh_d     = {dbit, sh_q[WIDTH-1:1]};
                borrow_d = borrow_nxt;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                    // Result lands in out on the same edge that enters DONE.
                    out_d   = {dbit, sh_q[WIDTH-1:1]};
`ifdef SERIAL_SUB16_FLAGS_EN
                    zr_d    = ({dbit, sh_q[WIDTH-1:1]} == '0);
                    ng_d    = dbit;
                    brw_d   = borrow_nxt;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB16_FLAGS_EN
            zr_q     <= 1'b0;
            ng_q     <= 1'b0;
            brw_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB16_FLAGS_EN
            zr_q     <= zr_d;
            ng_q     <= ng_d;
            brw_q    <= brw_d;
`endif
        end
    end

    assign out  = out_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

`ifdef SERIAL_SUB16_FLAGS_EN
    assign zr  = zr_q;
    assign ng  = ng_q;
    assign brw = brw_q;
`endif

endmodule

// File: tb/tb_serial_sub16.sv
// Directed self-checking bench for serial_sub16; honours SERIAL_SUB16_FLAGS_EN.
module tb_serial_sub16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        busy;
    logic        done;
`ifdef SERIAL_SUB16_FLAGS_EN
    logic        zr, ng, brw;
`endif

    int errors = 0;
    int checks = 0;

    serial_sub16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .out   (out),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_SUB16_FLAGS_EN
        ,
        .zr    (zr),
        .ng    (ng),
        .brw   (brw)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse; the next negedge is RUN cycle 1.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
        repeat (2) @(negedge clk);
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out: got %h expected 0000", out);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", busy, done);
        end
`ifdef SERIAL_SUB16_FLAGS_EN
        checks++;
        if ({zr, ng, brw} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {zr, ng, brw});
        end
`endif
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int busy_bad = 0;
        launch(16'd5, 16'd3);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
            a = 16'hFFFF;
            b = 16'h0000;
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL basic_busy16: got %0d bad cycles expected 0", busy_bad);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done17: got done=%b busy=%b expected 1 0", done, busy);
        end
        checks++;
        if (out !== 16'h0002) begin
            errors++;
            $display("FAIL basic_out: got %h expected 0002", out);
        end
`ifdef SERIAL_SUB16_FLAGS_EN
        checks++;
        if ({zr, ng, brw} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: got %b expected 000", {zr, ng, brw});
        end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || out !== 16'h0002) begin
            errors++;
            $display("FAIL basic_hold: got done=%b out=%h expected 0 0002", done, out);
        end
    endtask

    task automatic test_underflow();
        launch(16'h0000, 16'h0001);
        repeat (17) @(negedge clk);
        checks++;
        if (done !== 1'b1 || out !== 16'hFFFF) begin
            errors++;
            $display("FAIL underflow_out: got done=%b out=%h expected 1 ffff", done, out);
        end
`ifdef SERIAL_SUB16_FLAGS_EN
        checks++;
        if ({zr, ng, brw} !== 3'b011) begin
            errors++;
            $display("FAIL underflow_flags: got %b expected 011", {zr, ng, brw});
        end
`endif
    endtask

    task automatic test_equal();
        launch(16'h1234, 16'h1234);
        repeat (17) @(negedge clk);
        checks++;
        if (done !== 1'b1 || out !== 16'h0000) begin
            errors++;
            $display("FAIL equal_out: got done=%b out=%h expected 1 0000", done, out);
        end
`ifdef SERIAL_SUB16_FLAGS_EN
        checks++;
        if ({zr, ng, brw} !== 3'b100) begin
            errors++;
            $display("FAIL equal_flags: got %b expected 100", {zr, ng, brw});
        end
`endif
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        int first = 0;
        logic [15:0] got = 16'h0;
        launch(16'h8000, 16'h7FFF);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) first = k;
                got = out;
            end
            if (k == 5) begin
                a     = 16'd1;
                b     = 16'd1;
                start = 1'b1;
            end else if (k == 6) begin
                start = 1'b0;
            end
        end
        checks++;
        if (ndone != 1 || first != 17) begin
            errors++;
            $display("FAIL ignore_single_done: got %0d pulses first=%0d expected 1 at 17",
                     ndone, first);
        end
        checks++;
        if (got !== 16'h0001) begin
            errors++;
            $display("FAIL ignore_out: got %h expected 0001", got);
        end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        launch(16'hFFFF, 16'h0001);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000) begin
            errors++;
            $display("FAIL abort_state: got busy=%b done=%b out=%h expected 0 0 0000",
                     busy, done, out);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || out !== 16'h0000) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles out=%h expected 0 0000",
                     ndone, out);
        end
        launch(16'd10, 16'd4);
        repeat (17) @(negedge clk);
        checks++;
        if (done !== 1'b1 || out !== 16'h0006) begin
            errors++;
            $display("FAIL abort_recover: got done=%b out=%h expected 1 0006", done, out);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [15:0] ve [3];
        int idx = 0;
        int overlap = 0;
        va[0] = 16'h0100; vb[0] = 16'h0001; ve[0] = 16'h00FF;
        va[1] = 16'h0003; vb[1] = 16'h0005; ve[1] = 16'hFFFE;
        va[2] = 16'hABCD; vb[2] = 16'h1234; ve[2] = 16'h9999;
        @(negedge clk);
        a     = va[0];
        b     = vb[0];
        start = 1'b1;
        for (int k = 1; k <= 54; k++) begin
            @(negedge clk);
            if (busy === 1'b1 && done === 1'b1) overlap++;
            if (done === 1'b1) begin
                checks++;
                if (idx > 2 || k != 17 + 18 * idx || out !== ve[idx % 3]) begin
                    errors++;
                    $display("FAIL b2b_run%0d: got out=%h at cycle %0d expected %h at %0d",
                             idx, out, k, ve[idx % 3], 17 + 18 * idx);
                end
                idx++;
                if (idx < 3) begin
                    a = va[idx];
                    b = vb[idx];
                end
            end
        end
        start = 1'b0;
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d completions expected 3", idx);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL b2b_busy_done: got %0d overlap cycles expected 0", overlap);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_basic();
        test_underflow();
        test_equal();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
